// File: rtl/pipelined_norm_shifter.sv
// Two-stage barrel shifter: SHL / SHR / ROTL / leading-one normalise with LZC, shift and MSB position.
// Latency: result on out_valid 2 cycles after acceptance; 1 operand/cycle while out_ready is high.
// Backpressure: outputs hold while out_valid && !out_ready; fills to 2 entries then drops in_ready.
// Optional: define STICKY_EN to generate the SHR sticky bit (otherwise sticky is tied to 0).
module pipelined_norm_shifter #(
  parameter int WIDTH = 8,
  localparam int SHW = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] data_in,
  input  logic [SHW-1:0]   shift,
  input  logic [1:0]       mode,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] data_out,
  output logic [SHW-1:0]   shamt_out,
  output logic [SHW-1:0]   msb_pos,
  output logic             zero,
  output logic             sticky
);

  typedef enum logic [1:0] {
    MODE_SHL  = 2'b00,
    MODE_SHR  = 2'b01,
    MODE_ROTL = 2'b10,
    MODE_NORM = 2'b11
  } mode_t;

  localparam logic [SHW-1:0] MAX_POS = SHW'(WIDTH - 1);

  // Leading-zero count; an all-zero operand returns 0 and is flagged separately,
  // so the count never needs the extra bit that WIDTH itself would require.
  function automatic logic [SHW-1:0] lzc(input logic [WIDTH-1:0] d);
    logic [SHW-1:0] n;
    n = '0;
    for (int i = 0; i < WIDTH; i++) begin
      if (d[i]) n = SHW'(WIDTH - 1 - i);
    end
    return n;
  endfunction

  // Stage-1 holding registers
  logic             s1_valid;
  logic [WIDTH-1:0] s1_data;
  logic [SHW-1:0]   s1_shift;
  mode_t            s1_mode;
  logic [SHW-1:0]   s1_lz;
  logic             s1_zero;

  // Handshake
  logic s1_load;
  logic s2_load;

  // Stage-2 next-state values
  logic [2*WIDTH-1:0] rot_wide;
  logic [WIDTH-1:0]   nxt_data;
  logic [SHW-1:0]     nxt_shamt;
  logic [SHW-1:0]     nxt_msb;
  logic               nxt_zero;

  // S2 takes a new entry whenever its current result is gone or leaving this cycle;
  // in_ready depends on out_ready only, never on in_valid.
  assign s2_load  = s1_valid && (!out_valid || out_ready);
  assign in_ready = !s1_valid || s2_load;
  assign s1_load  = in_valid && in_ready;

  // Stage 1: capture operand, control and its leading-zero count
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid <= 1'b0;
      s1_data  <= '0;
      s1_shift <= '0;
      s1_mode  <= MODE_SHL;
      s1_lz    <= '0;
      s1_zero  <= 1'b0;
    end else begin
      if (s1_load) begin
        s1_valid <= 1'b1;
        s1_data  <= data_in;
        s1_shift <= shift;
        s1_mode  <= mode_t'(mode);
        s1_lz    <= lzc(data_in);
        s1_zero  <= ~|data_in;
      end else if (s2_load) begin
        s1_valid <= 1'b0;
      end
    end
  end

  // Rotate as the upper half of the doubled word shifted left
  assign rot_wide = {s1_data, s1_data} << s1_shift;

  // Stage 2 datapath: select the shifted result for the registered mode
  always_comb begin
    nxt_data  = s1_data;
    nxt_shamt = s1_shift;
    nxt_msb   = '0;
    nxt_zero  = 1'b0;
    case (s1_mode)
      MODE_SHL:  nxt_data = s1_data << s1_shift;
      MODE_SHR:  nxt_data = s1_data >> s1_shift;
      MODE_ROTL: nxt_data = rot_wide[2*WIDTH-1:WIDTH];
      MODE_NORM: begin
        if (s1_zero) begin
          nxt_data  = '0;
          nxt_shamt = '0;
          nxt_zero  = 1'b1;
        end else begin
          nxt_data  = s1_data << s1_lz;
          nxt_shamt = s1_lz;
          nxt_msb   = MAX_POS - s1_lz;
        end
      end
      default: nxt_data = s1_data;
    endcase
  end

  // Stage 2 output registers; hold while downstream stalls
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      data_out  <= '0;
      shamt_out <= '0;
      msb_pos   <= '0;
      zero      <= 1'b0;
    end else begin
      if (s2_load) begin
        out_valid <= 1'b1;
        data_out  <= nxt_data;
        shamt_out <= nxt_shamt;
        msb_pos   <= nxt_msb;
        zero      <= nxt_zero;
      end else if (out_ready) begin
        out_valid <= 1'b0;
      end
    end
  end

`ifdef STICKY_EN
  logic [WIDTH-1:0] sticky_mask;
  logic             nxt_sticky;
  logic             sticky_q;

  // Sticky: any '1' among the low bits that a logical right shift discards
  always_comb begin
    sticky_mask = ~({WIDTH{1'b1}} << s1_shift);
    nxt_sticky  = 1'b0;
    if (s1_mode == MODE_SHR) nxt_sticky = |(s1_data & sticky_mask);
  end

  // Sticky travels with the rest of the stage-2 result
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sticky_q <= 1'b0;
    end else if (s2_load) begin
      sticky_q <= nxt_sticky;
    end
  end

  assign sticky = sticky_q;
`else
  assign sticky = 1'b0;
`endif

endmodule

// File: tb/tb_pipelined_norm_shifter.sv
// Randomised + directed bench for pipelined_norm_shifter against an arithmetic reference model.
// Latency: checks the 2-cycle first-result latency and in-order delivery through a scoreboard queue.
// Backpressure: checks output stability while stalled, in_ready drop when full, and async reset flush.
module tb_pipelined_norm_shifter;

  localparam int W  = 8;
  localparam int SW = 3;
`ifdef STICKY_EN
  localparam bit STK = 1'b1;
`else
  localparam bit STK = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          rst_n;
  logic          in_valid;
  logic          in_ready;
  logic [W-1:0]  data_in;
  logic [SW-1:0] shift;
  logic [1:0]    mode;
  logic          out_valid;
  logic          out_ready;
  logic [W-1:0]  data_out;
  logic [SW-1:0] shamt_out;
  logic [SW-1:0] msb_pos;
  logic          zero;
  logic          sticky;

  typedef struct packed {
    logic [W-1:0]  d;
    logic [SW-1:0] sh;
    logic [SW-1:0] msb;
    logic          z;
    logic          st;
  } exp_t;

  exp_t sb[$];
  exp_t prev;
  exp_t lit_exp;
  logic lit_en   = 1'b0;
  logic hold_prev = 1'b0;
  int   last_acc = 0;
  int   checks   = 0;
  int   errors   = 0;

  pipelined_norm_shifter #(.WIDTH(W)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready),
    .data_in(data_in), .shift(shift), .mode(mode),
    .out_valid(out_valid), .out_ready(out_ready),
    .data_out(data_out), .shamt_out(shamt_out), .msb_pos(msb_pos),
    .zero(zero), .sticky(sticky)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Reference: plain integer arithmetic on the operand value
  function automatic exp_t model(input int d, input int s, input int m);
    exp_t e;
    int   r;
    int   lz;
    int   full;
    full = 2 ** W;
    e = '0;
    r = d;
    case (m)
      0: begin r = (d * (2 ** s)) % full; e.sh = SW'(s); end
      1: begin
        r = d / (2 ** s);
        e.sh = SW'(s);
        e.st = STK && ((d % (2 ** s)) != 0);
      end
      2: begin r = ((d * (2 ** s)) % full) + d / (2 ** (W - s)); e.sh = SW'(s); end
      default: begin
        if (d == 0) begin
          r = 0;
          e.z = 1'b1;
        end else begin
          lz = 0;
          while (r < full / 2) begin r = r * 2; lz++; end
          e.sh  = SW'(lz);
          e.msb = SW'(W - 1 - lz);
        end
      end
    endcase
    e.d = r[W-1:0];
    return e;
  endfunction

  // One clock: drive at negedge, settle, then account for the handshakes at the coming posedge
  task automatic cycle(input logic iv, input logic [W-1:0] d, input logic [SW-1:0] s,
                       input logic [1:0] m, input logic ordy);
    exp_t e;
    @(negedge clk);
    in_valid = iv; data_in = d; shift = s; mode = m; out_ready = ordy;
    #1;
    if (hold_prev) begin
      chk("hold_vld", out_valid, 1);
      chk("hold_dat", data_out, prev.d);
      chk("hold_sh", shamt_out, prev.sh);
      chk("hold_msb", msb_pos, prev.msb);
      chk("hold_z", zero, prev.z);
      chk("hold_st", sticky, prev.st);
    end
    hold_prev = out_valid && !out_ready;
    prev = '{d: data_out, sh: shamt_out, msb: msb_pos, z: zero, st: sticky};
    if (out_valid && out_ready) begin
      if (sb.size() == 0) begin
        chk("spurious", out_valid, 0);
      end else begin
        e = sb.pop_front();
        chk("dat", data_out, e.d);
        chk("sh", shamt_out, e.sh);
        chk("msb", msb_pos, e.msb);
        chk("z", zero, e.z);
        chk("st", sticky, e.st);
      end
    end
    last_acc = 0;
    if (in_valid && in_ready) begin
      sb.push_back(lit_en ? lit_exp : model(int'(d), int'(s), int'(m)));
      last_acc = 1;
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cycle(1'b0, '0, '0, 2'b00, 1'b1);
  endtask

  initial begin
    int sent;
    int acc_before;
    rst_n = 1'b1; in_valid = 1'b0; data_in = '0; shift = '0; mode = '0; out_ready = 1'b1;
    #2 rst_n = 1'b0;
    #1;
    chk("rst_ovld", out_valid, 0);
    chk("rst_dat", data_out, 0);
    chk("rst_sh", shamt_out, 0);
    chk("rst_msb", msb_pos, 0);
    chk("rst_z", zero, 0);
    chk("rst_st", sticky, 0);
    #10 rst_n = 1'b1;
    #1 chk("rst_rdy", in_ready, 1);

    // 1: SHL with latency check
    lit_en = 1'b1;
    lit_exp = '{d: 8'b10101000, sh: 3'd2, msb: 3'd0, z: 1'b0, st: 1'b0};
    cycle(1'b1, 8'b01101010, 3'd2, 2'b00, 1'b1);
    chk("t1_acc", last_acc, 1);
    lit_en = 1'b0;
    cycle(1'b0, '0, '0, 2'b00, 1'b1);
    chk("t1_lat1", out_valid, 0);
    cycle(1'b0, '0, '0, 2'b00, 1'b1);
    chk("t1_lat2", out_valid, 1);
    idle(2);

    // 2: SHR with discarded ones
    lit_en = 1'b1;
    lit_exp = '{d: 8'b00010111, sh: 3'd3, msb: 3'd0, z: 1'b0, st: STK};
    cycle(1'b1, 8'b10111011, 3'd3, 2'b01, 1'b1);
    lit_en = 1'b0;
    idle(3);

    // 3: ROTL then back-to-back shift of zero
    lit_en = 1'b1;
    lit_exp = '{d: 8'b11011101, sh: 3'd3, msb: 3'd0, z: 1'b0, st: 1'b0};
    cycle(1'b1, 8'b10111011, 3'd3, 2'b10, 1'b1);
    lit_exp = '{d: 8'b01011010, sh: 3'd0, msb: 3'd0, z: 1'b0, st: 1'b0};
    cycle(1'b1, 8'b01011010, 3'd0, 2'b10, 1'b1);
    chk("t3_acc2", last_acc, 1);
    lit_en = 1'b0;
    cycle(1'b0, '0, '0, 2'b00, 1'b1);
    chk("t3_v1", out_valid, 1);
    cycle(1'b0, '0, '0, 2'b00, 1'b1);
    chk("t3_v2", out_valid, 1);
    idle(2);

    // 4: NORM nonzero then NORM of zero
    lit_en = 1'b1;
    lit_exp = '{d: 8'b10110000, sh: 3'd3, msb: 3'd4, z: 1'b0, st: 1'b0};
    cycle(1'b1, 8'b00010110, 3'd5, 2'b11, 1'b1);
    lit_exp = '{d: 8'b00000000, sh: 3'd0, msb: 3'd0, z: 1'b1, st: 1'b0};
    cycle(1'b1, 8'b00000000, 3'd6, 2'b11, 1'b1);
    lit_en = 1'b0;
    idle(4);
    chk("t4_drain", sb.size(), 0);

    // 5: five SHL operands with out_ready low for 3 cycles
    sent = 0;
    for (int c = 0; c < 40; c++) begin
      acc_before = sent;
      cycle(sent < 5, W'($urandom), 3'd1, 2'b00, c >= 3);
      if (c < 3 && acc_before >= 2) chk("t5_full", in_ready, 0);
      if (last_acc != 0) sent++;
      if (sent == 5 && sb.size() == 0) break;
    end
    chk("t5_sent", sent, 5);
    chk("t5_drain", sb.size(), 0);

    // 6: asynchronous reset with both stages occupied
    cycle(1'b1, 8'h05, 3'd0, 2'b11, 1'b0);
    cycle(1'b1, 8'hFF, 3'd1, 2'b00, 1'b0);
    cycle(1'b0, '0, '0, 2'b00, 1'b0);
    chk("t6_full", out_valid, 1);
    chk("t6_pre", data_out, 8'hA0);
    #2 rst_n = 1'b0;
    #1;
    chk("t6_ovld", out_valid, 0);
    chk("t6_dat", data_out, 0);
    chk("t6_sh", shamt_out, 0);
    chk("t6_msb", msb_pos, 0);
    chk("t6_z", zero, 0);
    chk("t6_st", sticky, 0);
    sb.delete();
    hold_prev = 1'b0;
    @(negedge clk);
    #2 rst_n = 1'b1;
    #1 chk("t6_rdy", in_ready, 1);
    for (int i = 0; i < 4; i++) begin
      cycle(1'b0, '0, '0, 2'b00, 1'b1);
      chk("t6_stale", out_valid, 0);
    end

    // Random traffic with random backpressure
    for (int c = 0; c < 400; c++) begin
      logic [W-1:0] d;
      d = W'($urandom);
      if ($urandom_range(0, 3) == 0) d = d >> $urandom_range(0, W);
      cycle($urandom_range(0, 9) < 7, d, SW'($urandom), 2'($urandom), $urandom_range(0, 9) < 7);
    end
    for (int c = 0; c < 20; c++) begin
      if (sb.size() == 0) break;
      cycle(1'b0, '0, '0, 2'b00, 1'b1);
    end
    chk("rand_drain", sb.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/pipelined_norm_shifter.md
Name: pipelined_norm_shifter

Overview:
- Parametrised, two-stage pipelined barrel shifter with valid/ready handshake.
- Operates on WIDTH-bit operands with four modes: logical left, logical right, rotate left, and leading-one normalise.
- Normalise mode feeds the log/mantissa path of the minimally biased multipliers. It returns the normalised operand, the applied shift and the leading-one position.
- Sits between operand registers and the multiplier core; accepts one operand per cycle.

Parameters:
- WIDTH, 8, operand width in bits. Must be a power of two, >= 4.
- SHW, $clog2(WIDTH), shift-amount width. Derived; not overridden.

Ports:
- clk  in  1  clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- in_valid  in  1  input operand valid.
- in_ready  out  1  block can accept the operand this cycle.
- data_in  in  WIDTH  operand.
- shift  in  SHW  shift amount; ignored in NORM mode.
- mode  in  2  operation select: 00 SHL, 01 SHR, 10 ROTL, 11 NORM.
- out_valid  out  1  result valid.
- out_ready  in  1  downstream accepts the result.
- data_out  out  WIDTH  shifted or normalised result.
- shamt_out  out  SHW  shift actually applied; the leading-zero count in NORM mode.
- msb_pos  out  SHW  NORM mode: WIDTH-1-shamt_out. Other modes: 0.
- zero  out  1  NORM mode with data_in == 0.
- sticky  out  1  OR of bits shifted out in SHR mode (see Optional Feature).

Behaviour:
- Decided: one clock; reset is asynchronous and active-low. Ports are clk and rst_n.
- Reset values:
  - out_valid = 0; internal stage-1 valid = 0.
  - data_out, shamt_out, msb_pos, zero, sticky all = 0.
  - in_ready = 1 once reset is released.
- Transfers occur on the rising edge when valid && ready on the respective side.
- Stage 1 (S1):
  - Registers data_in, shift and mode.
  - Computes the leading-zero count (LZC) of data_in combinationally before the register. The LZC is stored.
- Stage 2 (S2):
  - Performs the shift using the S1 values and registers all outputs.
- Latency: a result appears on out_valid exactly 2 cycles after acceptance, provided no backpressure.
- Throughput: 1 operand per cycle while out_ready = 1.
- Advance rules:
  - S2 loads when S1 is valid and (!out_valid || out_ready).
  - S1 loads when in_valid && in_ready.
  - in_ready = !s1_valid || s2_load. It is combinational from out_ready; no combinational path from in_valid.
- Backpressure: while out_valid && !out_ready, all outputs hold stable. The pipeline fills to 2 entries, then in_ready = 0. No loss, duplication or reordering.
- SHL mode:
  - data_out = (data_in << shift) truncated to WIDTH bits; zero-fill.
  - shamt_out = shift.
- SHR mode:
  - data_out = data_in >> shift, logical; zero-fill.
  - shamt_out = shift.
- ROTL mode:
  - data_out = data_in rotated left by shift.
  - shamt_out = shift.
- NORM mode:
  - lz = LZC(data_in); data_out = data_in << lz, so the MSB is 1.
  - shamt_out = lz; msb_pos = WIDTH-1-lz.
  - Fraction for the multiplier = data_out[WIDTH-2:0].
- NORM with data_in == 0: data_out = 0, shamt_out = 0, msb_pos = 0, zero = 1.
- zero = 0 in all other cases.
- shift == 0 in any shift mode: data_out = data_in and sticky = 0.
- Simultaneous accept and output consume in the same cycle: both occur; the pipeline stays full at 1 operand per cycle.
- Reset asserted mid-operation: in-flight operands are discarded immediately and asynchronously. Outputs return to reset values; no result is produced after release.

Optional Feature:
- Macro: STICKY_EN.
- Defined: in SHR mode, sticky = OR of the shift low bits of data_in discarded by the shift. It is registered alongside data_out. sticky = 0 in other modes.
- Not defined: no sticky logic is generated; the sticky port is tied to 0.

Test Plan:
1. SHL, data_in = 8'b01101010, shift = 2, out_ready = 1 -> 2 cycles later: data_out = 8'b10101000, shamt_out = 2.
2. SHR, data_in = 8'b10111011, shift = 3 -> data_out = 8'b00010111. sticky = 1 with STICKY_EN, sticky = 0 without it.
3. ROTL, data_in = 8'b10111011, shift = 3 -> data_out = 8'b11011101. A back-to-back second operand with shift = 0 -> data_out = data_in on the following cycle.
4. NORM, data_in = 8'b00010110 -> data_out = 8'b10110000, shamt_out = 3, msb_pos = 4, zero = 0. Then NORM, data_in = 0 -> data_out = 0, zero = 1.
5. Stream 5 SHL operands (shift = 1) with out_ready held low for 3 cycles -> in_ready drops after 2 accepts; outputs hold stable. After release, all 5 results emerge in order, none lost or duplicated.
6. Assert rst_n = 0 with both stages full -> out_valid = 0 and all outputs = 0 immediately. After release: in_ready = 1 and no stale result appears.
